// File: rtl/game_timer_pkg.sv
// Shared types and constants for the scoreboard game clock.
package timer_pkg;

    // Top-level control states.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSE   = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;

    // Counting direction latched when a start is accepted.
    typedef enum logic {
        MODE_DOWN = 1'b0,
        MODE_UP   = 1'b1
    } mode_t;

    // Largest legal value of a BCD units / minutes-tens digit and of the seconds-tens digit.
    localparam int unsigned DIGIT_MAX    = 9;
    localparam int unsigned TENS_SEC_MAX = 5;

    // One MM:SS display value split into its four digits.
    typedef struct packed {
        logic [3:0] min_ten;
        logic [3:0] min;
        logic [2:0] dec;
        logic [3:0] sec;
    } bcd_time_t;

    // Saturate a 4-bit digit at max_v.
    function automatic logic [3:0] clamp4(input logic [3:0] d, input logic [3:0] max_v);
        return (d > max_v) ? max_v : d;
    endfunction

    // Turn raw load values into a displayable time: any digit beyond its range is forced to its maximum.
    function automatic bcd_time_t clamp_time(input logic [7:0] min_bcd, input logic [6:0] sec_bcd);
        bcd_time_t t;
        t.min_ten = clamp4(min_bcd[7:4], 4'(DIGIT_MAX));
        t.min     = clamp4(min_bcd[3:0], 4'(DIGIT_MAX));
        t.dec     = (sec_bcd[6:4] > 3'(TENS_SEC_MAX)) ? 3'(TENS_SEC_MAX) : sec_bcd[6:4];
        t.sec     = clamp4(sec_bcd[3:0], 4'(DIGIT_MAX));
        return t;
    endfunction

endpackage

// File: rtl/game_timer_if.sv
// Control and display bundle between game control logic and the game clock.
interface game_timer_if;

    logic       load_i;
    logic [7:0] load_min_i;
    logic [6:0] load_sec_i;
    logic       start_i;
    logic       pause_i;
    logic       mode_i;

    logic [3:0] min_ten_digit;
    logic [3:0] min_digit;
    logic [2:0] dec_digit;
    logic [3:0] sec_digit;
    logic       running_o;
    logic       expired_o;
    logic       tick_o;
    logic       expire_pulse_o;

    // Game control side: issues commands, watches the display and flags.
    modport master (
        output load_i, load_min_i, load_sec_i, start_i, pause_i, mode_i,
        input  min_ten_digit, min_digit, dec_digit, sec_digit,
        input  running_o, expired_o, tick_o, expire_pulse_o
    );

    // Timer side.
    modport slave (
        input  load_i, load_min_i, load_sec_i, start_i, pause_i, mode_i,
        output min_ten_digit, min_digit, dec_digit, sec_digit,
        output running_o, expired_o, tick_o, expire_pulse_o
    );

endinterface

// File: rtl/game_timer_bcd_digit_cnt.sv
// One BCD digit of the clock: wraps 0..MAX in either direction and flags carry/borrow to the next digit.
module bcd_digit_cnt #(
    parameter int unsigned       W       = 4,
    parameter int unsigned       MAX     = 9,
    parameter logic [W-1:0]      RST_VAL = '0
) (
    input  logic         clk_tm,
    input  logic         rst_tm,
    input  logic         en,
    input  logic         up,
    input  logic         set,
    input  logic [W-1:0] set_val,
    output logic [W-1:0] digit,
    output logic         co
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] r_digit;

    // Carry (up) or borrow (down) is raised in the same cycle the digit wraps, so the next digit steps on that edge.
    assign co    = en & (up ? (r_digit == MAX_V) : (r_digit == '0));
    assign digit = r_digit;

    // Digit register: load has priority over stepping.
    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_tm or posedge rst_tm) begin
        if (rst_tm) begin
            r_digit <= RST_VAL;
        end else if (set) begin
            r_digit <= set_val;
        end else if (en) begin
            if (up) begin
                r_digit <= (r_digit == MAX_V) ? '0 : r_digit + W'(1);
            end else begin
                r_digit <= (r_digit == '0) ? MAX_V : r_digit - W'(1);
            end
        end
    end

endmodule

// File: rtl/game_timer.sv
// Scoreboard game clock: MM:SS up/down timer with 1 Hz prescaler, run/pause control and expiry signalling.
module game_timer
    import timer_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 25000000,
    parameter logic [7:0]  PRESET_MIN  = 8'h10,
    parameter logic [6:0]  PRESET_SEC  = 7'h00
) (
    input  logic         clk_tm,
    input  logic         rst_tm,
    game_timer_if.slave  bus
);

    localparam int unsigned  PW = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
    localparam logic [PW-1:0] TC = PW'(CLK_FREQ_HZ - 1);
    localparam logic [3:0]   D_MAX = 4'(DIGIT_MAX);
    localparam logic [2:0]   T_MAX = 3'(TENS_SEC_MAX);

    state_t        r_state;
    state_t        w_state_nxt;
    mode_t         r_mode;
    logic [PW-1:0] r_presc;
    logic          r_tick;
    logic          r_expire_pulse;
    logic          r_running;
    logic          r_expired;

    logic          w_presc_clr;
    logic          w_presc_inc;
    logic          w_step;
    logic          w_mode_latch;
    logic          w_tick;
    logic          w_expire;

    logic [3:0]    w_min_ten;
    logic [3:0]    w_min;
    logic [2:0]    w_dec;
    logic [3:0]    w_sec;
    logic          w_co_sec;
    logic          w_co_dec;
    logic          w_co_min;
    logic          w_chain_out;

    bcd_time_t     w_load_val;
    logic          w_up;
    logic          w_zero;
    logic          w_full;
    logic          w_pre_zero;
    logic          w_pre_full;
    logic          w_hold;
    logic          w_last;
    logic          w_tc;
    logic          w_start_ok;

    assign w_load_val = clamp_time(bus.load_min_i, bus.load_sec_i);
    assign w_up       = (r_mode == MODE_UP);
    assign w_tc       = (r_presc == TC);

    // Time landmarks used to stop the clock at either end of its range.
    assign w_zero     = (w_min_ten == 4'd0) && (w_min == 4'd0) && (w_dec == 3'd0) && (w_sec == 4'd0);
    assign w_pre_zero = (w_min_ten == 4'd0) && (w_min == 4'd0) && (w_dec == 3'd0) && (w_sec == 4'd1);
    assign w_full     = (w_min_ten == D_MAX) && (w_min == D_MAX) && (w_dec == T_MAX) && (w_sec == D_MAX);
    assign w_pre_full = (w_min_ten == D_MAX) && (w_min == D_MAX) && (w_dec == T_MAX) && (w_sec == D_MAX - 4'd1);

    // Already at the end value: tick but do not move the digits (saturation instead of wrap).
    assign w_hold = w_up ? w_full : w_zero;
    // This tick lands on (or sits at) the end value, so the period is over.
    assign w_last = w_up ? (w_pre_full | w_full) : (w_pre_zero | w_zero);

    // A down-count from 00:00 would expire instantly, so such a start is refused.
    assign w_start_ok = bus.start_i && !((bus.mode_i == MODE_DOWN) && w_zero);

    // Next-state and per-cycle control decode; load beats pause, pause beats start and the terminal count.
    // NOTE: every output of this block gets a default first, otherwise unassigned paths infer latches.
    always_comb begin
        w_state_nxt  = r_state;
        w_presc_clr  = 1'b0;
        w_presc_inc  = 1'b0;
        w_step       = 1'b0;
        w_mode_latch = 1'b0;
        w_tick       = 1'b0;
        w_expire     = 1'b0;
        if (bus.load_i) begin
            w_state_nxt = ST_IDLE;
            w_presc_clr = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE, ST_PAUSE: begin
                    if (w_start_ok) begin
                        w_state_nxt  = ST_RUN;
                        w_mode_latch = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (bus.pause_i) begin
                        w_state_nxt = ST_PAUSE;
                    end else if (w_tc) begin
                        w_presc_clr = 1'b1;
                        w_tick      = 1'b1;
                        w_step      = !w_hold;
                        if (w_last) begin
                            w_state_nxt = ST_EXPIRED;
                            w_expire    = 1'b1;
                        end
                    end else begin
                        w_presc_inc = 1'b1;
                    end
                end
                ST_EXPIRED: begin
                    w_state_nxt = ST_EXPIRED;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // State, mode latch and registered flag/pulse outputs.
    always_ff @(posedge clk_tm or posedge rst_tm) begin
        if (rst_tm) begin
            r_state        <= ST_IDLE;
            r_mode         <= MODE_DOWN;
            r_tick         <= 1'b0;
            r_expire_pulse <= 1'b0;
            r_running      <= 1'b0;
            r_expired      <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            if (w_mode_latch) begin
                r_mode <= mode_t'(bus.mode_i);
            end
            r_tick         <= w_tick;
            r_expire_pulse <= w_expire;
            r_running      <= (w_state_nxt == ST_RUN);
            r_expired      <= (w_state_nxt == ST_EXPIRED);
        end
    end

    // Sub-second prescaler; it simply stops outside RUN so a pause keeps the fractional second.
    always_ff @(posedge clk_tm or posedge rst_tm) begin
        if (rst_tm) begin
            r_presc <= '0;
        end else if (w_presc_clr) begin
            r_presc <= '0;
        end else if (w_presc_inc) begin
            r_presc <= r_presc + PW'(1);
        end
    end

    // Digit chain, seconds units first; each stage steps on the carry/borrow of the one below.
    bcd_digit_cnt #(.W(4), .MAX(DIGIT_MAX), .RST_VAL(PRESET_SEC[3:0])) u_sec (
        .clk_tm(clk_tm), .rst_tm(rst_tm), .en(w_step), .up(w_up),
        .set(bus.load_i), .set_val(w_load_val.sec), .digit(w_sec), .co(w_co_sec)
    );

    bcd_digit_cnt #(.W(3), .MAX(TENS_SEC_MAX), .RST_VAL(PRESET_SEC[6:4])) u_dec (
        .clk_tm(clk_tm), .rst_tm(rst_tm), .en(w_co_sec), .up(w_up),
        .set(bus.load_i), .set_val(w_load_val.dec), .digit(w_dec), .co(w_co_dec)
    );

    bcd_digit_cnt #(.W(4), .MAX(DIGIT_MAX), .RST_VAL(PRESET_MIN[3:0])) u_min (
        .clk_tm(clk_tm), .rst_tm(rst_tm), .en(w_co_dec), .up(w_up),
        .set(bus.load_i), .set_val(w_load_val.min), .digit(w_min), .co(w_co_min)
    );

    bcd_digit_cnt #(.W(4), .MAX(DIGIT_MAX), .RST_VAL(PRESET_MIN[7:4])) u_min_ten (
        .clk_tm(clk_tm), .rst_tm(rst_tm), .en(w_co_min), .up(w_up),
        .set(bus.load_i), .set_val(w_load_val.min_ten), .digit(w_min_ten), .co(w_chain_out)
    );

    // The FSM withholds the step at 00:00 / 99:59, so the top of the chain must never wrap.
    assert property (@(posedge clk_tm) disable iff (rst_tm) !w_chain_out);

    assign bus.min_ten_digit  = w_min_ten;
    assign bus.min_digit      = w_min;
    assign bus.dec_digit      = w_dec;
    assign bus.sec_digit      = w_sec;
    assign bus.running_o      = r_running;
    assign bus.expired_o      = r_expired;
    assign bus.tick_o         = r_tick;
    assign bus.expire_pulse_o = r_expire_pulse;

endmodule

// File: tb/tb_game_timer.sv
// Self-checking bench for game_timer: seconds-based reference model compared every cycle, plus directed literal checks.
module tb_game_timer;

    localparam int CLK_HZ  = 4;
    localparam int MAX_SEC = 99 * 60 + 59;

    logic clk_tm = 1'b0;
    logic rst_tm = 1'b1;
    bit   cmp_en = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    game_timer_if bus();

    game_timer #(.CLK_FREQ_HZ(CLK_HZ)) dut (
        .clk_tm (clk_tm),
        .rst_tm (rst_tm),
        .bus    (bus)
    );

    always #5 clk_tm = ~clk_tm;

    task automatic check(input string name, input int act, input int exp_v);
        n_checks++;
        if (act == exp_v) n_pass++;
        else $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp_v, $time);
    endtask

    // Display as a decimal MMSS number, e.g. 09:59 -> 959.
    function automatic int dut_disp();
        return int'(bus.min_ten_digit) * 1000 + int'(bus.min_digit) * 100 +
               int'(bus.dec_digit) * 10 + int'(bus.sec_digit);
    endfunction

    function automatic int clampi(input int d, input int mx);
        return (d > mx) ? mx : d;
    endfunction

    // Reference model: time held as a plain count of seconds, progress as RUN cycles into the current second.
    int m_secs  = 600;
    int m_phase = 0;
    bit m_mode  = 0;
    bit m_run   = 0;
    bit m_exp   = 0;
    bit m_tick  = 0;
    bit m_xp    = 0;

    always @(posedge clk_tm or posedge rst_tm) begin
        m_tick = 0;
        m_xp   = 0;
        if (rst_tm) begin
            m_secs = 600; m_phase = 0; m_mode = 0; m_run = 0; m_exp = 0;
        end else if (bus.load_i) begin
            m_secs = (clampi(int'(bus.load_min_i[7:4]), 9) * 10 + clampi(int'(bus.load_min_i[3:0]), 9)) * 60 +
                     clampi(int'(bus.load_sec_i[6:4]), 5) * 10 + clampi(int'(bus.load_sec_i[3:0]), 9);
            m_phase = 0; m_run = 0; m_exp = 0;
        end else if (m_run) begin
            if (bus.pause_i) begin
                m_run = 0;
            end else begin
                m_phase++;
                if (m_phase == CLK_HZ) begin
                    m_phase = 0;
                    m_tick  = 1;
                    m_secs  = m_mode ? ((m_secs + 1 > MAX_SEC) ? MAX_SEC : m_secs + 1) : m_secs - 1;
                    if ((m_mode && m_secs == MAX_SEC) || (!m_mode && m_secs == 0)) begin
                        m_run = 0; m_exp = 1; m_xp = 1;
                    end
                end
            end
        end else if (!m_exp && bus.start_i && !(!bus.mode_i && m_secs == 0)) begin
            m_run  = 1;
            m_mode = bus.mode_i;
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk_tm) begin
        if (cmp_en) begin
            check("m_disp",    dut_disp(), (m_secs / 60) * 100 + (m_secs % 60));
            check("m_running", int'(bus.running_o), int'(m_run));
            check("m_expired", int'(bus.expired_o), int'(m_exp));
            check("m_tick",    int'(bus.tick_o), int'(m_tick));
            check("m_xpulse",  int'(bus.expire_pulse_o), int'(m_xp));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_tm);
    endtask

    task automatic do_start(input bit m);
        bus.start_i = 1'b1; bus.mode_i = m;
        @(negedge clk_tm);
        bus.start_i = 1'b0; bus.mode_i = 1'b0;
    endtask

    task automatic do_pause();
        bus.pause_i = 1'b1;
        @(negedge clk_tm);
        bus.pause_i = 1'b0;
    endtask

    task automatic do_load(input logic [7:0] mn, input logic [6:0] sc);
        bus.load_i = 1'b1; bus.load_min_i = mn; bus.load_sec_i = sc;
        @(negedge clk_tm);
        bus.load_i = 1'b0;
    endtask

    task automatic do_all(input logic [7:0] mn, input logic [6:0] sc);
        bus.load_i = 1'b1; bus.load_min_i = mn; bus.load_sec_i = sc;
        bus.pause_i = 1'b1; bus.start_i = 1'b1; bus.mode_i = 1'b0;
        @(negedge clk_tm);
        bus.load_i = 1'b0; bus.pause_i = 1'b0; bus.start_i = 1'b0;
    endtask

    initial begin
        bus.load_i = 1'b0; bus.load_min_i = '0; bus.load_sec_i = '0;
        bus.start_i = 1'b0; bus.pause_i = 1'b0; bus.mode_i = 1'b0;
        cyc(3);
        rst_tm = 1'b0;
        cmp_en = 1'b1;
        cyc(1);

        // Reset state
        check("rst_disp",    dut_disp(), 1000);
        check("rst_running", int'(bus.running_o), 0);
        check("rst_expired", int'(bus.expired_o), 0);
        check("rst_tick",    int'(bus.tick_o), 0);

        // First tick exactly CLK_HZ cycles after start
        do_start(1'b0);
        cyc(3);
        check("first_pre_tick", int'(bus.tick_o), 0);
        check("first_pre_disp", dut_disp(), 1000);
        check("first_running",  int'(bus.running_o), 1);
        cyc(1);
        check("first_tick",     int'(bus.tick_o), 1);
        check("first_disp",     dut_disp(), 959);

        // Borrow chain down to expiry
        do_load(8'h01, 7'h00);
        check("load_disp", dut_disp(), 100);
        check("load_idle", int'(bus.running_o), 0);
        do_start(1'b0);
        cyc(4);
        check("borrow_disp", dut_disp(), 59);
        cyc(232);
        check("near_end_disp", dut_disp(), 1);
        cyc(3);
        check("near_end_exp", int'(bus.expired_o), 0);
        cyc(1);
        check("end_disp",    dut_disp(), 0);
        check("end_xpulse",  int'(bus.expire_pulse_o), 1);
        check("end_tick",    int'(bus.tick_o), 1);
        check("end_expired", int'(bus.expired_o), 1);
        check("end_running", int'(bus.running_o), 0);
        cyc(1);
        check("xpulse_once", int'(bus.expire_pulse_o), 0);
        do_start(1'b0);
        do_start(1'b1);
        cyc(2);
        check("exp_start_ign", int'(bus.running_o), 0);
        check("exp_held",      int'(bus.expired_o), 1);

        // Pause mid-second preserves the fraction
        do_load(8'h05, 7'h00);
        do_start(1'b0);
        cyc(2);
        do_pause();
        check("pause_running", int'(bus.running_o), 0);
        cyc(10);
        check("pause_disp", dut_disp(), 500);
        do_start(1'b0);
        cyc(1);
        check("resume_no_tick", int'(bus.tick_o), 0);
        cyc(1);
        check("resume_tick", int'(bus.tick_o), 1);
        check("resume_disp", dut_disp(), 459);

        // Pause coinciding with terminal count: no tick
        cyc(3);
        do_pause();
        check("pause_tc_tick", int'(bus.tick_o), 0);
        check("pause_tc_disp", dut_disp(), 459);
        do_start(1'b0);
        cyc(1);
        check("pause_tc_resume", dut_disp(), 458);

        // Count-up saturation
        do_load(8'h99, 7'h58);
        do_start(1'b1);
        cyc(3);
        check("up_pre_disp", dut_disp(), 9958);
        cyc(1);
        check("up_disp",    dut_disp(), 9959);
        check("up_expired", int'(bus.expired_o), 1);
        check("up_xpulse",  int'(bus.expire_pulse_o), 1);
        cyc(8);
        check("up_no_wrap", dut_disp(), 9959);

        // Clamp and control priority
        do_load(8'hAF, 7'h7C);
        check("clamp_disp",    dut_disp(), 9959);
        check("clamp_expired", int'(bus.expired_o), 0);
        do_load(8'h02, 7'h30);
        do_start(1'b0);
        cyc(2);
        do_all(8'h03, 7'h15);
        check("prio_running", int'(bus.running_o), 0);
        check("prio_disp",    dut_disp(), 315);
        cyc(6);
        check("prio_idle_disp", dut_disp(), 315);
        do_load(8'h00, 7'h00);
        do_start(1'b0);
        cyc(5);
        check("zero_start_ign", int'(bus.running_o), 0);
        check("zero_disp",      dut_disp(), 0);
        do_start(1'b1);
        cyc(4);
        check("zero_up_disp", dut_disp(), 1);

        // Asynchronous reset mid-RUN, between clock edges
        cyc(1);
        #2;
        rst_tm = 1'b1;
        #1;
        check("arst_disp",    dut_disp(), 1000);
        check("arst_running", int'(bus.running_o), 0);
        cyc(2);
        rst_tm = 1'b0;
        cyc(1);
        check("arst_idle", int'(bus.running_o), 0);
        do_start(1'b0);
        cyc(4);
        check("arst_restart", dut_disp(), 959);

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/game_timer.md
# game_timer

Parametrised scoreboard game clock: an MM:SS timer with two BCD minute digits, a loadable start value, run/pause control, and a count-down or count-up mode. It derives a 1 Hz tick from the system clock and raises an expiry flag and pulse at the end of the period. It drives the scoreboard digit display path and informs game control logic when a period ends.

## Interface
- CLK_FREQ_HZ, 25000000, clock cycles per second; prescaler width = $clog2(CLK_FREQ_HZ)
- PRESET_MIN, 8'h10, BCD minutes loaded at reset
- PRESET_SEC, 7'h00, BCD seconds loaded at reset (tens in [6:4], units in [3:0])

Ports:
- clk_tm  in  1  system clock
- rst_tm  in  1  reset; one clock; reset is asynchronous and active-high
- load_i  in  1  one-cycle pulse; load load_min_i/load_sec_i
- load_min_i  in  8  BCD minutes (tens [7:4], units [3:0])
- load_sec_i  in  7  BCD seconds (tens [6:4], units [3:0])
- start_i  in  1  one-cycle pulse; run
- pause_i  in  1  one-cycle pulse; pause
- mode_i  in  1  0 = count down, 1 = count up; sampled only when start is accepted
- min_ten_digit  out  4  minutes tens, BCD
- min_digit  out  4  minutes units, BCD
- dec_digit  out  3  seconds tens, 0–5
- sec_digit  out  4  seconds units, BCD
- running_o  out  1  high in RUN
- expired_o  out  1  high in EXPIRED
- tick_o  out  1  one-cycle pulse on each counted second
- expire_pulse_o  out  1  one-cycle pulse on entry to EXPIRED

## Operation
- States: IDLE, RUN, PAUSE, EXPIRED. Reset: IDLE, digits = PRESET, prescaler 0, mode latch 0, all flags and pulses 0.
- Control priority within one cycle: load > pause > start.
- load_i in any state: go to IDLE, clear the prescaler, and load the digits.
  - Clamp invalid BCD: any units or minutes-tens digit above 9 becomes 9.
  - Seconds tens above 5 becomes 5.
- start_i in IDLE or PAUSE: go to RUN and latch mode_i.
  - Ignore start if the latched mode would be down and the time is 00:00.
  - Ignore start in RUN and EXPIRED.
- pause_i in RUN: go to PAUSE. The prescaler holds its value, so the fractional second is preserved. pause_i has no effect in other states.
- RUN: the prescaler counts 0..CLK_FREQ_HZ-1. On the terminal count it wraps to 0, tick_o fires, and the time steps by 1 s.
- Down mode: units-first BCD decrement with borrow.
  - sec 0 → 9 borrows from dec.
  - dec 0 → 5 borrows from min.
  - min 0 → 9 borrows from min_ten.
  - Reaching 00:00 goes to EXPIRED.
- Up mode: BCD increment with carry (sec 9 → 0, dec 5 → 0, min 9 → 0). Reaching 99:59 goes to EXPIRED; the time saturates and never wraps.
- EXPIRED: digits are frozen, expired_o = 1. Only load_i or reset leaves this state.
- Reset mid-run: immediate return to the reset values.

## Timing
- All outputs are registered. Digits, tick_o, and the state change update on the same clock edge as the prescaler wrap.
- The first step occurs exactly CLK_FREQ_HZ cycles after the edge that accepts start_i.
- Pause/resume:
  - A RUN stretch of k cycles, then pause, then start gives the next tick after CLK_FREQ_HZ−k further RUN cycles.
  - Pause and terminal count in the same cycle: pause wins, and no tick occurs.
- On the final step:
  - expire_pulse_o and tick_o are both high in the same cycle.
  - running_o drops on that edge.
  - expired_o rises on that edge.
- Load is visible on the outputs the cycle after load_i.

## Structure
- Package timer_pkg:
  - state enum
  - BCD limits (DIGIT_MAX = 9, TENS_SEC_MAX = 5)
  - mode encodings
- Sub-module bcd_digit_cnt, parametrised by MAX:
  - inputs: en, up, set, set_val
  - outputs: digit, carry/borrow-out
  - instantiated four times and chained.
- Top level: FSM, prescaler, mode latch, clamp logic, pulse registers.

## Test plan
- Use CLK_FREQ_HZ = 4 for all scenarios.
- Reset: outputs are 10:00, IDLE, all flags 0. Start with mode 0: first tick_o at cycle 4 after acceptance, display 09:59.
- Borrow chain: load 01:00, start in down mode. After 4 cycles the display is 00:59. After 59 further ticks:
  - display 00:00
  - expire_pulse_o high for 1 cycle
  - expired_o held high; further start_i is ignored.
- Pause mid-second: run 2 cycles, pause 10 cycles, then start. The next tick comes 2 RUN cycles later, and the digits do not change during the pause.
- Count-up saturation: load 99:58, start with mode 1.
  - First tick gives 99:59 and EXPIRED in the same cycle.
  - No wrap to 00:00.
- Clamp and priority:
  - load 8'hAF / 7'h7C displays 99:59.
  - load_i, pause_i, and start_i together while in RUN give IDLE with the loaded value.
  - Start at 00:00 in mode 0 is ignored.
- Async reset asserted mid-RUN between clock edges: outputs return to 10:00/IDLE immediately, without waiting for a clock edge.
